// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, writeback FSM states and opcode class helpers.
package alu_pkg;

   localparam logic [3:0] OP_OR  = 4'd0;
   localparam logic [3:0] OP_AND = 4'd1;
   localparam logic [3:0] OP_XOR = 4'd2;
   localparam logic [3:0] OP_ADD = 4'd3;
   localparam logic [3:0] OP_SUB = 4'd4;
   localparam logic [3:0] OP_SLT = 4'd5;
   localparam logic [3:0] OP_MUL = 4'd6;
   localparam logic [3:0] OP_DIV = 4'd7;
   localparam logic [3:0] OP_SLL = 4'd8;
   localparam logic [3:0] OP_SRL = 4'd9;
   localparam logic [3:0] OP_SRA = 4'd10;
   localparam logic [3:0] OP_ROL = 4'd11;
   localparam logic [3:0] OP_ROR = 4'd12;

   typedef enum logic [1:0] {IDLE, ZCAP, WB, WB_HI} wb_state_t;

   function automatic logic op_legal(input logic [3:0] op);
      return op <= OP_ROR;
   endfunction

   // MUL and DIV produce a 64-bit result that lands in the HI/LO pair.
   function automatic logic op_hilo(input logic [3:0] op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/alu_writeback_seq_z_register.sv
// Z register: wide capture register with load enable and synchronous clear.
module z_register #(
   parameter int W = 64
) (
   input  logic         clock,
   input  logic         clear,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clock) begin
      if (clear)   q <= '0;
      else if (en) q <= d;
   end

endmodule

// File: rtl/alu_writeback_seq.sv
// ALU writeback sequencer: captures the result into Z, then writes the register file or HI/LO.
// Optional macro ALU_HILO_TO_RF_EN: MUL/DIV additionally write LO to dest and HI to dest+1.
module alu_writeback_seq
   import alu_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 4
) (
   input  logic                  clock,
   input  logic                  clear,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [3:0]            alu_op,
   input  logic [2*DATA_W-1:0]   alu_result,
   input  logic [REG_ADDR_W-1:0] dest_reg,
   output logic                  rf_we,
   output logic [REG_ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0]     rf_wdata,
   output logic [DATA_W-1:0]     hi_q,
   output logic [DATA_W-1:0]     lo_q,
   output logic                  zero_flag,
   output logic                  done,
   output logic                  op_err
);

   wb_state_t               state, state_nx;
   logic [3:0]              op_q;
   logic [REG_ADDR_W-1:0]   dest_q;
   logic [2*DATA_W-1:0]     z_q;
   logic [DATA_W-1:0]       z_lo, z_hi;
   logic                    accept;
   logic                    we_nx, done_nx, err_nx, hilo_we;
   logic [REG_ADDR_W-1:0]   waddr_nx;
   logic [DATA_W-1:0]       wdata_nx;

   assign in_ready = (state == IDLE);
   assign accept   = in_valid && in_ready;
   assign z_lo     = z_q[DATA_W-1:0];
   assign z_hi     = z_q[2*DATA_W-1:DATA_W];

   // Z loads on the accept edge so upstream only has to hold data for that cycle.
   z_register #(.W(2*DATA_W)) u_z (
      .clock (clock),
      .clear (clear),
      .en    (accept),
      .d     (alu_result),
      .q     (z_q)
   );

   always_ff @(posedge clock) begin
      if (clear) state <= IDLE;
      else       state <= state_nx;
   end

   // Outputs are computed one state ahead and registered, so pulses line up with the state they belong to.
   always_comb begin
      state_nx = state;
      we_nx    = 1'b0;
      waddr_nx = rf_waddr;
      wdata_nx = rf_wdata;
      done_nx  = 1'b0;
      err_nx   = 1'b0;
      hilo_we  = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nx = ZCAP;
               err_nx   = !op_legal(alu_op);
            end
         end
         ZCAP: begin
            if (!op_legal(op_q)) begin
               state_nx = IDLE;
            end else begin
               state_nx = WB;
               hilo_we  = op_hilo(op_q);
`ifdef ALU_HILO_TO_RF_EN
               we_nx    = 1'b1;
               waddr_nx = dest_q;
               wdata_nx = z_lo;
               done_nx  = !op_hilo(op_q);
`else
               if (!op_hilo(op_q)) begin
                  we_nx    = 1'b1;
                  waddr_nx = dest_q;
                  wdata_nx = z_lo;
               end
               done_nx  = 1'b1;
`endif
            end
         end
         WB: begin
            state_nx = IDLE;
`ifdef ALU_HILO_TO_RF_EN
            if (op_hilo(op_q)) begin
               state_nx = WB_HI;
               we_nx    = 1'b1;
               waddr_nx = dest_q + REG_ADDR_W'(1);
               wdata_nx = z_hi;
               done_nx  = 1'b1;
            end
`endif
         end
         WB_HI:   state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         rf_we     <= 1'b0;
         rf_waddr  <= '0;
         rf_wdata  <= '0;
         done      <= 1'b0;
         op_err    <= 1'b0;
         zero_flag <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         op_q      <= '0;
         dest_q    <= '0;
      end else begin
         rf_we    <= we_nx;
         rf_waddr <= waddr_nx;
         rf_wdata <= wdata_nx;
         done     <= done_nx;
         op_err   <= err_nx;
         if (accept) begin
            op_q      <= alu_op;
            dest_q    <= dest_reg;
            zero_flag <= (alu_result[DATA_W-1:0] == '0);
         end
         if (hilo_we) begin
            hi_q <= z_hi;
            lo_q <= z_lo;
         end
      end
   end

endmodule

// File: tb/tb_alu_writeback_seq.sv
// Scoreboard bench for alu_writeback_seq: randomized ops against a cycle-stamped event model.
module tb_alu_writeback_seq;

   logic        clock = 1'b0;
   logic        clear;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  alu_op;
   logic [63:0] alu_result;
   logic [3:0]  dest_reg;
   logic        rf_we;
   logic [3:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [31:0] hi_q, lo_q;
   logic        zero_flag, done, op_err;

   always #5 clock = ~clock;

   alu_writeback_seq #(.DATA_W(32), .REG_ADDR_W(4)) dut (
      .clock      (clock),
      .clear      (clear),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .alu_op     (alu_op),
      .alu_result (alu_result),
      .dest_reg   (dest_reg),
      .rf_we      (rf_we),
      .rf_waddr   (rf_waddr),
      .rf_wdata   (rf_wdata),
      .hi_q       (hi_q),
      .lo_q       (lo_q),
      .zero_flag  (zero_flag),
      .done       (done),
      .op_err     (op_err)
   );

   typedef struct {int c; logic [3:0] a; logic [31:0] d;} rf_ev_t;
   typedef struct {int c; logic [31:0] hi; logic [31:0] lo; logic z;} st_ev_t;

   rf_ev_t      rf_q[$];
   st_ev_t      done_q[$];
   st_ev_t      err_q[$];
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   int          next_free = 0;
   logic [31:0] mhi = '0, mlo = '0;
   logic        mon_en = 1'b0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
      end
   endtask

   // Reference model: a single accepted op becomes a list of timed output events.
   task automatic model_accept(input logic [3:0] op, input logic [63:0] res, input logic [3:0] dest);
      int k;
      logic z;
      logic [3:0] d1;
      k  = cyc;
      z  = (res[31:0] == 32'd0);
      d1 = dest + 4'd1;
      if (op > 4'd12) begin
         err_q.push_back(st_ev_t'{k + 1, mhi, mlo, z});
         next_free = k + 2;
      end else if (op == 4'd6 || op == 4'd7) begin
         mhi = res[63:32];
         mlo = res[31:0];
`ifdef ALU_HILO_TO_RF_EN
         rf_q.push_back(rf_ev_t'{k + 2, dest, res[31:0]});
         rf_q.push_back(rf_ev_t'{k + 3, d1, res[63:32]});
         done_q.push_back(st_ev_t'{k + 3, mhi, mlo, z});
         next_free = k + 4;
`else
         done_q.push_back(st_ev_t'{k + 2, mhi, mlo, z});
         next_free = k + 3;
`endif
      end else begin
         rf_q.push_back(rf_ev_t'{k + 2, dest, res[31:0]});
         done_q.push_back(st_ev_t'{k + 2, mhi, mlo, z});
         next_free = k + 3;
      end
   endtask

   // Called just after a rising edge; drives one cycle of input.
   task automatic step(input logic v, input logic [3:0] op, input logic [63:0] res, input logic [3:0] dest);
      chk("in_ready", in_ready, cyc >= next_free);
      in_valid   = v;
      alu_op     = op;
      alu_result = res;
      dest_reg   = dest;
      if (v && cyc >= next_free) model_accept(op, res, dest);
      @(posedge clock); #1;
   endtask

   task automatic idle_step();
      step(1'b0, 4'($urandom), {$urandom, $urandom}, 4'($urandom));
   endtask

   // Events due after the clear edge are abandoned; events visible this cycle still stand.
   task automatic do_clear(input int n);
      while (rf_q.size() > 0 && rf_q[$].c > cyc) void'(rf_q.pop_back());
      while (done_q.size() > 0 && done_q[$].c > cyc) void'(done_q.pop_back());
      while (err_q.size() > 0 && err_q[$].c > cyc) void'(err_q.pop_back());
      clear    = 1'b1;
      in_valid = 1'b0;
      repeat (n) @(posedge clock);
      #1;
      clear     = 1'b0;
      mhi       = '0;
      mlo       = '0;
      next_free = 0;
   endtask

   task automatic drain();
      int n = 0;
      while ((cyc < next_free + 1 || rf_q.size() + done_q.size() + err_q.size() > 0) && n < 20) begin
         idle_step();
         n++;
      end
      chk("drain_queues_empty", 64'(rf_q.size() + done_q.size() + err_q.size()), 64'd0);
   endtask

   always @(negedge clock) begin
      if (mon_en) begin
         logic exp_rf, exp_done, exp_err;
         exp_rf   = rf_q.size() > 0 && rf_q[0].c <= cyc;
         exp_done = done_q.size() > 0 && done_q[0].c <= cyc;
         exp_err  = err_q.size() > 0 && err_q[0].c <= cyc;
         chk("rf_we", rf_we, exp_rf);
         chk("done", done, exp_done);
         chk("op_err", op_err, exp_err);
         if (exp_rf) begin
            rf_ev_t e;
            e = rf_q.pop_front();
            if (rf_we === 1'b1) begin
               chk("rf_waddr", rf_waddr, e.a);
               chk("rf_wdata", rf_wdata, e.d);
            end
         end
         if (exp_done) begin
            st_ev_t e;
            e = done_q.pop_front();
            if (done === 1'b1) begin
               chk("done_hi_q", hi_q, e.hi);
               chk("done_lo_q", lo_q, e.lo);
               chk("done_zero_flag", zero_flag, e.z);
            end
         end
         if (exp_err) begin
            st_ev_t e;
            e = err_q.pop_front();
            if (op_err === 1'b1) begin
               chk("err_hi_q", hi_q, e.hi);
               chk("err_lo_q", lo_q, e.lo);
               chk("err_zero_flag", zero_flag, e.z);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
      $fatal(1);
   end

   initial begin
      logic [63:0] res;
      in_valid = 1'b0; alu_op = '0; alu_result = '0; dest_reg = '0; clear = 1'b0;
      @(posedge clock); #1;
      do_clear(2);
      chk("reset_in_ready", in_ready, 1'b1);
      chk("reset_rf_we", rf_we, 1'b0);
      chk("reset_hi_q", hi_q, 32'd0);
      chk("reset_lo_q", lo_q, 32'd0);
      chk("reset_zero_flag", zero_flag, 1'b0);
      chk("reset_done", done, 1'b0);
      mon_en = 1'b1;

      // ADD to R5
      step(1'b1, 4'd3, 64'h0000_0000_0000_0007, 4'd5);
      drain();
      // MUL into HI/LO (and R9/R10 with the register-file option)
      step(1'b1, 4'd6, 64'h0000_0001_FFFF_FFFE, 4'd9);
      drain();
      chk("mul_hi_q", hi_q, 32'h1);
      chk("mul_lo_q", lo_q, 32'hFFFF_FFFE);
      // DIV with dest 15: the HI half wraps to R0 when enabled
      step(1'b1, 4'd7, 64'h1234_5678_9ABC_DEF0, 4'd15);
      drain();
      // illegal opcode leaves HI/LO alone
      step(1'b1, 4'd14, 64'hDEAD_BEEF_0000_0000, 4'd2);
      drain();
      chk("illegal_hi_q", hi_q, 32'h1234_5678);
      chk("illegal_lo_q", lo_q, 32'h9ABC_DEF0);
      // second request while busy is ignored
      step(1'b1, 4'd3, 64'h0000_0000_0000_00AA, 4'd1);
      step(1'b1, 4'd4, 64'h0000_0000_0000_00BB, 4'd2);
      step(1'b1, 4'd4, 64'h0000_0000_0000_00CC, 4'd2);
      drain();
      // clear while in ZCAP abandons the SUB
      step(1'b1, 4'd4, 64'h0000_0005_0000_0000, 4'd3);
      chk("zcap_zero_flag", zero_flag, 1'b1);
      do_clear(1);
      chk("clear_in_ready", in_ready, 1'b1);
      chk("clear_zero_flag", zero_flag, 1'b0);
      chk("clear_hi_q", hi_q, 32'd0);
      drain();

      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 49) == 0) begin
            do_clear(1);
         end else begin
            res = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) res[31:0] = 32'd0;
            step($urandom_range(0, 9) < 7, 4'($urandom_range(0, 15)), res, 4'($urandom));
         end
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
